rv32_lsu: RTL
=============

# rv32_lsu

Load/store unit for the RV32I core, sitting between the decode/execute stage and the data-memory port. Accepts one decoded LOAD/STORE operation at a time (funct3 width code, effective address, store data), generates byte enables and lane-replicated write data, and runs a request/grant/response handshake to memory. Extracts and sign/zero-extends load data, then returns it with its destination register to writeback.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting for mem_rvalid after grant before the load is aborted with an error; range 1..255.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  operation offered by execute.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_store  in  1  1 = store (STORE opcode), 0 = load (LOAD opcode).
- req_funct3  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  effective address (RV32_DATA_T).
- req_wdata  in  32  rs2 value for stores.
- req_rd  in  5  load destination register.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_rd  out  5  req_rd for loads; 0 for stores and errors.
- rsp_err  out  1  illegal funct3, misaligned access (trap build only) or timeout.
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we  out  1  write enable.
- mem_addr  out  32  word address; bits [1:0] always 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  32  load data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch all request fields. Illegal funct3 (loads 011/110/111; stores anything other than 000/001/010) -> RESP with error, no memory access. Otherwise -> REQ.
- REQ: mem_req=1, with mem_we/addr/be/wdata stable. On mem_gnt: stores -> RESP; loads -> WAIT, timeout counter cleared.
- WAIT: counter increments each cycle. On mem_rvalid: capture extended data -> RESP. When the counter reaches TIMEOUT_CYCLES with no rvalid -> RESP with error. rvalid in the same cycle as expiry wins.
- RESP: rsp_valid=1 for exactly one cycle -> IDLE.
- Byte lanes, off = addr[1:0]:
  - B: be = 0001<<off; wdata = {4{wdata[7:0]}}.
  - H: be = 0011<<off; wdata = {2{wdata[15:0]}}.
  - W: be = 1111.
- Load extract: select the byte or halfword at off. B/H sign-extend; BU/HU zero-extend.
- Misaligned: H with addr[0]=1, or W with addr[1:0]≠00. Handling depends on configuration.
- mem_rvalid and mem_gnt are ignored outside WAIT and REQ respectively.

## Timing
- Reset values: req_ready=0 during reset, then 1. All other outputs are 0. FSM resets to IDLE and the counter to 0.
- Reset mid-operation: the transaction is abandoned and mem_req drops the cycle after rst. A late rvalid is ignored.
- Accept at cycle 0. mem_req asserts at cycle 1.
- Store with immediate grant: rsp_valid at cycle 2.
- Load with gnt at cycle 1 and rvalid at cycle 2: rsp_valid at cycle 3 (minimum load latency 3).
- Error without memory access: rsp_valid at cycle 1.
- One transaction outstanding. A new request is accepted at the earliest in the cycle after rsp_valid.

## Configuration
- RV_LSU_MISALIGN_TRAP_EN defined: a misaligned access makes no memory request. The LSU goes directly to RESP with rsp_err=1 (rsp_valid at cycle 1).
- Undefined: low address bits are forced aligned (H clears bit 0; W clears bits 1:0) and the access proceeds normally with rsp_err=0.

## Structure
- Shared package additions:
  - RV32_LSU_STATE enum (IDLE/REQ/WAIT/RESP).
  - RV32_MEM_WIDTH enum (MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_BU=3'b100, MEM_HU=3'b101).
  - RV32_BE_T (logic [3:0]).
- One combinational sub-module, rv32_lsu_load_align: inputs width code, offset and mem_rdata; output extended data.

## Test plan
- Reset, then SW addr 0x1000, wdata 0xDEADBEEF, gnt immediate -> mem_addr 0x1000, be 1111, wdata 0xDEADBEEF, we=1; rsp_valid at cycle 2, rsp_err=0, rsp_rd=0.
- SB addr 0x1003, wdata 0x000000A5 -> be 1000, mem_addr 0x1000, wdata 0xA5A5A5A5.
- LB addr 0x2002, rdata 0x12F03456 -> rsp_rdata 0xFFFFFFF0. LBU at the same address -> 0x000000F0. LHU addr 0x2002 -> 0x000012F0. rsp_rd echoes req_rd.
- LH addr 0x2001: with the macro -> no mem_req, rsp_err=1 at cycle 1. Without the macro -> mem_addr 0x2000, be 0011, normal response.
- Load with gnt delayed 3 cycles and rvalid never arriving, TIMEOUT_CYCLES=4 -> mem_req held through the gnt delay; rsp_err=1, rsp_rdata=0; req_ready returns high after the response.
- rst asserted while in WAIT, rvalid arriving 2 cycles later -> no rsp_valid; the next load completes correctly.

Source files
------------

// File: rtl/rv32_lsu_pkg.sv
// Shared RV32 load/store types: LSU FSM states, memory width codes, byte-enable type.
package rv32_lsu_pkg;

  typedef logic [31:0] RV32_DATA_T;
  typedef logic [3:0]  RV32_BE_T;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} RV32_LSU_STATE;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } RV32_MEM_WIDTH;

  function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
    if (store) return f3 inside {3'b000, 3'b001, 3'b010};
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

endpackage

// File: rtl/rv32_lsu_load_align.sv
// Load data extraction: picks the byte/halfword at the lane offset and sign/zero-extends it.
module rv32_lsu_load_align
  import rv32_lsu_pkg::*;
(
  input  RV32_MEM_WIDTH width,
  input  logic [1:0]    off,
  input  RV32_DATA_T    rdata,
  output RV32_DATA_T    data
);

  RV32_DATA_T shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (width)
      MEM_B:   data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_BU:  data = {24'b0, shifted[7:0]};
      MEM_H:   data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_HU:  data = {16'b0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// RV32I load/store unit: req/gnt/rvalid memory handshake with load timeout.
// Define RV_LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.
module rv32_lsu
  import rv32_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  RV32_LSU_STATE state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  RV32_DATA_T    rsp_rdata_q, rsp_rdata_d;
  logic [4:0]    rsp_rd_q, rsp_rd_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  RV32_DATA_T    mem_addr_q, mem_addr_d;
  RV32_BE_T      mem_be_q, mem_be_d;
  RV32_DATA_T    mem_wdata_q, mem_wdata_d;
  RV32_MEM_WIDTH width_q, width_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    rd_q, rd_d;

  logic          req_misalign, req_err;
  logic [1:0]    req_off;
  RV32_BE_T      req_be;
  RV32_DATA_T    req_wdata_lane;
  RV32_DATA_T    load_data;

  rv32_lsu_load_align u_load_align (
    .width (width_q),
    .off   (off_q),
    .rdata (mem_rdata),
    .data  (load_data)
  );

  always_comb begin
    req_misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    req_off = req_addr[1:0];
`ifdef RV_LSU_MISALIGN_TRAP_EN
    req_err = !funct3_legal(req_store, req_funct3) || req_misalign;
`else
    req_err = !funct3_legal(req_store, req_funct3);
    // Force-align: the offset also drives load extraction, so both stay consistent.
    if (req_misalign) req_off = (req_funct3[1:0] == 2'b01) ? {req_addr[1], 1'b0} : 2'b00;
`endif
    case (req_funct3[1:0])
      2'b00: begin
        req_be         = 4'b0001 << req_off;
        req_wdata_lane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be         = 4'b0011 << req_off;
        req_wdata_lane = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be         = 4'b1111;
        req_wdata_lane = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    rsp_rd_d    = '0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    width_d     = width_q;
    off_d       = off_q;
    rd_d        = rd_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          width_d     = RV32_MEM_WIDTH'(req_funct3);
          off_d       = req_off;
          rd_d        = req_rd;
          mem_we_d    = req_store;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_be_d    = req_be;
          mem_wdata_d = req_wdata_lane;
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = REQ;
            mem_req_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          rsp_rd_d    = rd_q;
        end else if (cnt_d == TMO_LIMIT) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      width_q     <= MEM_B;
      off_q       <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rd_q    <= rsp_rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      width_q     <= width_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
